rom_loader: RTL and testbench

Write-side companion to the instruction ROM: accepts 32-bit instruction words over a valid/ready stream and writes them into the byte-wide instruction memory, one byte per clock, in big-endian order (MSB at lowest address). The CPU's ROM read port reassembles these same bytes. It sits between the program source (test harness or boot UART) and the memory's byte write port, and runs before the CPU is released from reset.

---
 rtl/rom_loader_pkg.sv | 34 +++
 rtl/rom_loader_be_word_serializer.sv | 49 ++++
 rtl/rom_loader.sv | 176 +++++++++++++++++
 tb/tb_rom_loader.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rom_loader_pkg.sv
// Shared types and helpers for the instruction ROM loader.
// Optional feature macro used by rom_loader: ROM_LOADER_CHECKSUM_EN.
package rom_loader_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCEPT,
        WRITE,
        DONE
    } state_t;

    localparam int BYTES_PER_WORD = 4;

    // Big-endian byte select: idx 0 is the most significant byte.
    function automatic logic [7:0] be_byte(input logic [31:0] w, input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = w[31:24];
            2'd1:    b = w[23:16];
            2'd2:    b = w[15:8];
            default: b = w[7:0];
        endcase
        return b;
    endfunction

    // True when all four bytes starting at p land inside a memory of 'depth' bytes.
    // Computed in 33 bits so that an address range wrapping past 2^32 is rejected.
    function automatic logic word_fits(input logic [31:0] p, input int unsigned depth);
        logic [32:0] end_addr;
        end_addr = {1'b0, p} + 33'd3;
        return end_addr < {1'b0, depth};
    endfunction

endpackage

// File: rtl/rom_loader_be_word_serializer.sv
// Holds one 32-bit word and emits it as four registered byte writes,
// most significant byte first. A new load may land on the fourth byte
// cycle so consecutive words stream without a gap.
module be_word_serializer
    import rom_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [31:0] word_in,
    output logic [1:0]  idx,
    output logic [7:0]  mem_data,
    output logic        mem_wr_n
);

    logic [31:0] word_q;
    logic        active;

    // Word storage; only meaningful while active, so it needs no reset.
    always_ff @(posedge clk) begin
        if (load) begin
            word_q <= word_in;
        end
    end

    // Byte counter and registered write-port outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active   <= 1'b0;
            idx      <= 2'd0;
            mem_data <= 8'h00;
            mem_wr_n <= 1'b1;
        end else if (load) begin
            active   <= 1'b1;
            idx      <= 2'd0;
            mem_data <= be_byte(word_in, 2'd0);
            mem_wr_n <= 1'b0;
        end else if (active) begin
            if (idx == 2'd3) begin
                active   <= 1'b0;
                mem_wr_n <= 1'b1;
            end else begin
                idx      <= idx + 2'd1;
                mem_data <= be_byte(word_q, idx + 2'd1);
            end
        end
    end

endmodule

// File: rtl/rom_loader.sv
// Streams 32-bit instruction words into a byte-wide instruction memory,
// big-endian, one byte per clock. Holds the load FSM, the write pointer
// and the alignment/range checks; byte sequencing is in be_word_serializer.
// Optional macro ROM_LOADER_CHECKSUM_EN adds a 32-bit sum of written words.
module rom_loader
    import rom_loader_pkg::*;
#(
    parameter int unsigned DEPTH = 100
)
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] base_addr,
    input  logic        word_valid,
    input  logic [31:0] word_data,
    input  logic        word_last,
    output logic        word_ready,
    output logic        mem_wr_n,
    output logic [31:0] mem_addr,
    output logic [7:0]  mem_data,
    output logic        busy,
    output logic        done,
    output logic        err
`ifdef ROM_LOADER_CHECKSUM_EN
    ,
    output logic [31:0] checksum
`endif
);

    state_t      state, state_d;
    logic [31:0] ptr, ptr_next, word_base;
    logic        last_q;
    logic        hs, load, ptr_load, ptr_inc, err_set, err_clr, ready_d;
    logic [1:0]  idx;

    assign hs        = word_valid && word_ready;
    assign ptr_next  = ptr + 32'(BYTES_PER_WORD);
    // A word accepted on the last byte cycle lands at the already-advanced pointer.
    assign word_base = (state == WRITE) ? ptr_next : ptr;
    // Ready is asserted in ACCEPT, and one cycle early on the final byte of a
    // non-last word so the next word can overlap it.
    assign ready_d   = (state_d == ACCEPT) || (state == WRITE && idx == 2'd2 && !last_q);

    // Next-state and control strobes.
    always_comb begin
        state_d  = state;
        load     = 1'b0;
        ptr_load = 1'b0;
        ptr_inc  = 1'b0;
        err_set  = 1'b0;
        err_clr  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (base_addr[1:0] != 2'b00) begin
                        err_set = 1'b1;
                        state_d = DONE;
                    end else begin
                        err_clr  = 1'b1;
                        ptr_load = 1'b1;
                        state_d  = ACCEPT;
                    end
                end
            end
            ACCEPT: begin
                if (hs) begin
                    if (word_fits(ptr, DEPTH)) begin
                        load    = 1'b1;
                        state_d = WRITE;
                    end else begin
                        err_set = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            WRITE: begin
                if (idx == 2'd3) begin
                    ptr_inc = 1'b1;
                    if (last_q) begin
                        state_d = DONE;
                    end else if (hs) begin
                        if (word_fits(ptr_next, DEPTH)) begin
                            load    = 1'b1;
                            state_d = WRITE;
                        end else begin
                            err_set = 1'b1;
                            state_d = DONE;
                        end
                    end else begin
                        state_d = ACCEPT;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register and registered status/handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            word_ready <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_d;
            word_ready <= ready_d;
            busy       <= (state_d != IDLE);
            done       <= (state_d == DONE);
        end
    end

    // Sticky error, write pointer and latched last flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err    <= 1'b0;
            ptr    <= 32'd0;
            last_q <= 1'b0;
        end else begin
            if (err_set) begin
                err <= 1'b1;
            end else if (err_clr) begin
                err <= 1'b0;
            end
            if (ptr_load) begin
                ptr <= base_addr;
            end else if (ptr_inc) begin
                ptr <= ptr_next;
            end
            if (load) begin
                last_q <= word_last;
            end
        end
    end

    // Byte address: word base on the first byte, then one step per byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_addr <= 32'd0;
        end else if (load) begin
            mem_addr <= word_base;
        end else if (state == WRITE && idx != 2'd3) begin
            mem_addr <= mem_addr + 32'd1;
        end
    end

`ifdef ROM_LOADER_CHECKSUM_EN
    // Running sum of every word that passes the range check.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            checksum <= 32'd0;
        end else if (state == IDLE && start) begin
            checksum <= 32'd0;
        end else if (load) begin
            checksum <= checksum + word_data;
        end
    end
`endif

    be_word_serializer u_ser (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .word_in  (word_data),
        .idx      (idx),
        .mem_data (mem_data),
        .mem_wr_n (mem_wr_n)
    );

endmodule

// File: tb/tb_rom_loader.sv
// Directed, table-driven bench for rom_loader.
module tb_rom_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] base_addr = 32'd0;
    logic        word_valid = 1'b0;
    logic [31:0] word_data = 32'd0;
    logic        word_last = 1'b0;
    logic        word_ready, mem_wr_n, busy, done, err;
    logic [31:0] mem_addr;
    logic [7:0]  mem_data;
`ifdef ROM_LOADER_CHECKSUM_EN
    logic [31:0] checksum;
`endif

    rom_loader #(.DEPTH(100)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .base_addr  (base_addr),
        .word_valid (word_valid),
        .word_data  (word_data),
        .word_last  (word_last),
        .word_ready (word_ready),
        .mem_wr_n   (mem_wr_n),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .busy       (busy),
        .done       (done),
        .err        (err)
`ifdef ROM_LOADER_CHECKSUM_EN
        ,
        .checksum   (checksum)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Observed strobes, ready cycles and done pulses.
    logic [31:0] s_addr[$];
    logic [7:0]  s_data[$];
    int          s_cyc[$];
    int          r_cyc[$];
    int          done_cnt = 0;
    int          done_cyc = -1;

    always @(negedge clk) begin
        if (!mem_wr_n) begin
            s_addr.push_back(mem_addr);
            s_data.push_back(mem_data);
            s_cyc.push_back(cyc);
        end
        if (word_ready) r_cyc.push_back(cyc);
        if (done) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        s_addr.delete();
        s_data.delete();
        s_cyc.delete();
        r_cyc.delete();
        done_cnt = 0;
        done_cyc = -1;
    endtask

    logic [31:0] wbuf[4];

    // Runs one load of n words from wbuf, holding word_valid across words.
    task automatic run_load(input logic [31:0] base, input int n, output int t_start);
        int g;
        clear_mon();
        start     = 1'b1;
        base_addr = base;
        t_start   = cyc;
        step();
        start = 1'b0;
        for (int i = 0; i < n; i++) begin
            word_valid = 1'b1;
            word_data  = wbuf[i];
            word_last  = (i == n - 1);
            g = 0;
            while (!word_ready && done_cnt == 0 && g < 40) begin
                step();
                g++;
            end
            if (done_cnt != 0) break;
            if (!word_ready) begin
                check("ready_wait", word_ready, 1);
                break;
            end
            step();
        end
        word_valid = 1'b0;
        word_last  = 1'b0;
        g = 0;
        while (done_cnt == 0 && g < 40) begin
            step();
            g++;
        end
        step();
        check("done_pulses", done_cnt, 1);
        check("busy_after", busy, 0);
    endtask

    typedef struct {
        logic [31:0] base;
        logic [31:0] word;
        logic        exp_err;
        int          exp_n;
        logic [7:0]  b0, b1, b2, b3;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int t0;
        logic [7:0] eb[4];
        logic [7:0] exp1[12];

        #200000;
        $display("FAIL global_timeout: got stuck, want finish");
        $fatal(1, "timeout");
    end

    initial begin
        int t0;
        logic [7:0] eb[4];
        logic [7:0] exp1[12];

        vecs[0] = '{32'd0,          32'h12345678, 1'b0, 4, 8'h12, 8'h34, 8'h56, 8'h78};
        vecs[1] = '{32'd4,          32'hDEADBEEF, 1'b0, 4, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        vecs[2] = '{32'd96,         32'hA5C30F81, 1'b0, 4, 8'hA5, 8'hC3, 8'h0F, 8'h81};
        vecs[3] = '{32'd100,        32'h11223344, 1'b1, 0, 8'h00, 8'h00, 8'h00, 8'h00};
        vecs[4] = '{32'd2,          32'h55667788, 1'b1, 0, 8'h00, 8'h00, 8'h00, 8'h00};
        vecs[5] = '{32'hFFFFFFFC,   32'h99AABBCC, 1'b1, 0, 8'h00, 8'h00, 8'h00, 8'h00};
        vecs[6] = '{32'd8,          32'h000000FF, 1'b0, 4, 8'h00, 8'h00, 8'h00, 8'hFF};

        // Reset values
        repeat (3) step();
        check("rst_word_ready", word_ready, 0);
        check("rst_mem_wr_n", mem_wr_n, 1);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_data", mem_data, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Three-word program at address 0
        exp1 = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h20, 8'h09, 8'h00, 8'h0A,
                 8'h01, 8'h09, 8'h50, 8'h20};
        wbuf[0] = 32'h20080005;
        wbuf[1] = 32'h2009000A;
        wbuf[2] = 32'h01095020;
        run_load(32'd0, 3, t0);
        check("prog_strobes", s_addr.size(), 12);
        if (s_addr.size() == 12) begin
            for (int i = 0; i < 12; i++) begin
                check($sformatf("prog_addr%0d", i), s_addr[i], i);
                check($sformatf("prog_data%0d", i), s_data[i], exp1[i]);
            end
            check("prog_no_gap", s_cyc[11] - s_cyc[0], 11);
            check("prog_done_time", done_cyc, s_cyc[11] + 1);
        end
        check("prog_err", err, 0);
        check("ready_count", r_cyc.size(), 3);
        if (r_cyc.size() == 3) begin
            check("ready_first", r_cyc[0], t0 + 1);
            check("ready_gap1", r_cyc[1] - r_cyc[0], 4);
            check("ready_gap2", r_cyc[2] - r_cyc[1], 4);
        end

        // Table of single-word loads
        for (int v = 0; v < 7; v++) begin
            wbuf[0] = vecs[v].word;
            eb = '{vecs[v].b0, vecs[v].b1, vecs[v].b2, vecs[v].b3};
            run_load(vecs[v].base, 1, t0);
            check($sformatf("v%0d_err", v), err, vecs[v].exp_err);
            check($sformatf("v%0d_strobes", v), s_addr.size(), vecs[v].exp_n);
            if (s_addr.size() == vecs[v].exp_n) begin
                for (int j = 0; j < vecs[v].exp_n; j++) begin
                    check($sformatf("v%0d_addr%0d", v, j), s_addr[j], vecs[v].base + j);
                    check($sformatf("v%0d_data%0d", v, j), s_data[j], eb[j]);
                end
            end
        end

        // Misaligned start: err and done the cycle after start, then cleared by an aligned start
        wbuf[0] = 32'h01020304;
        run_load(32'd2, 1, t0);
        check("mis_done_time", done_cyc, t0 + 1);
        check("mis_err", err, 1);
        check("mis_strobes", s_addr.size(), 0);
        run_load(32'd0, 1, t0);
        check("mis_err_cleared", err, 0);
        check("mis_then_strobes", s_addr.size(), 4);

        // Two words at 96: second overflows and is dropped
        wbuf[0] = 32'hAABBCCDD;
        wbuf[1] = 32'h11111111;
        run_load(32'd96, 2, t0);
        check("ovf_strobes", s_addr.size(), 4);
        if (s_addr.size() == 4) begin
            check("ovf_addr_first", s_addr[0], 96);
            check("ovf_addr_last", s_addr[3], 99);
            check("ovf_data_last", s_data[3], 8'hDD);
            check("ovf_done_time", done_cyc, s_cyc[3] + 1);
        end
        check("ovf_err", err, 1);

        // Reset in the middle of a word
        clear_mon();
        start     = 1'b1;
        base_addr = 32'd0;
        step();
        start      = 1'b0;
        word_valid = 1'b1;
        word_data  = 32'hCAFEF00D;
        word_last  = 1'b1;
        begin
            int g = 0;
            while (!word_ready && g < 20) begin
                step();
                g++;
            end
        end
        check("rstmid_ready", word_ready, 1);
        step();
        word_valid = 1'b0;
        word_last  = 1'b0;
        step();
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("rstmid_wr_n", mem_wr_n, 1);
        check("rstmid_addr", mem_addr, 0);
        check("rstmid_data", mem_data, 0);
        check("rstmid_busy", busy, 0);
        check("rstmid_ready0", word_ready, 0);
        check("rstmid_done", done, 0);
        check("rstmid_err", err, 0);
        repeat (3) step();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) step();
        check("rstmid_partial", s_addr.size(), 2);
        if (s_addr.size() == 2) begin
            check("rstmid_b0", s_data[0], 8'hCA);
            check("rstmid_b1", s_data[1], 8'hFE);
        end
        wbuf[0] = 32'hCAFEF00D;
        run_load(32'd8, 1, t0);
        check("after_rst_strobes", s_addr.size(), 4);
        if (s_addr.size() == 4) begin
            check("after_rst_addr0", s_addr[0], 8);
            check("after_rst_data3", s_data[3], 8'h0D);
        end
        check("after_rst_err", err, 0);

`ifdef ROM_LOADER_CHECKSUM_EN
        // Checksum wraps modulo 2^32
        wbuf[0] = 32'hFFFFFFFF;
        wbuf[1] = 32'h00000002;
        run_load(32'd0, 2, t0);
        check("checksum", checksum, 32'h00000001);
        step();
        check("checksum_hold", checksum, 32'h00000001);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
